sig_control_timed: RTL and testbench

//   Parametrised highway/country-road traffic signal controller. Replaces event-delay

---
 rtl/sig_control_timed.sv | 140 ++++++++++++++
 tb/tb_sig_control_timed.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_control_timed.sv
// Highway/country-road traffic signal controller with a saturating dwell counter
// providing yellow, all-red, highway minimum-green and country maximum-green timing.
module sig_control_timed #(
    parameter int Y2R_CYCLES      = 3,
    parameter int R2G_CYCLES      = 2,
    parameter int HWY_MIN_GREEN   = 8,
    parameter int CNTRY_MAX_GREEN = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
    input  logic       preempt,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Last dwell value of each timed interval: dwell counts completed cycles from 0.
    localparam logic [CNT_W-1:0] Y2R_LAST   = CNT_W'(Y2R_CYCLES - 1);
    localparam logic [CNT_W-1:0] R2G_LAST   = CNT_W'(R2G_CYCLES - 1);
    localparam logic [CNT_W-1:0] HMG_LAST   = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CMG_LAST   = CNT_W'(CNTRY_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] DWELL_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DWELL_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DWELL_ONE  = CNT_W'(1);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [CNT_W-1:0] dwell_r;

    // State and dwell registers; dwell restarts on every state change.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= S0;
            dwell_r <= DWELL_ZERO;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                dwell_r <= DWELL_ZERO;
            end else if (dwell_r != DWELL_MAX) begin
                dwell_r <= dwell_r + DWELL_ONE;
            end else begin
                dwell_r <= dwell_r;
            end
        end
    end

    // Next-state selection; yellow and all-red always run to completion.
    always_comb begin
        next_state_s = S0;
        case (state_r)
            S0: begin
                if (X && !preempt && (dwell_r >= HMG_LAST)) begin
                    next_state_s = S1;
                end else begin
                    next_state_s = S0;
                end
            end
            S1: begin
                if (dwell_r == Y2R_LAST) begin
                    next_state_s = S2;
                end else begin
                    next_state_s = S1;
                end
            end
            S2: begin
                if (dwell_r == R2G_LAST) begin
                    if (preempt) begin
                        next_state_s = S0;
                    end else begin
                        next_state_s = S3;
                    end
                end else begin
                    next_state_s = S2;
                end
            end
            S3: begin
                if (!X || preempt || (dwell_r == CMG_LAST)) begin
                    next_state_s = S4;
                end else begin
                    next_state_s = S3;
                end
            end
            S4: begin
                if (dwell_r == Y2R_LAST) begin
                    next_state_s = S0;
                end else begin
                    next_state_s = S4;
                end
            end
            default: next_state_s = S0;
        endcase
    end

    // Signal-head decode; an illegal encoding shows red on both roads.
    always_comb begin
        hwy   = RED;
        cntry = RED;
        case (state_r)
            S0: begin
                hwy   = GREEN;
                cntry = RED;
            end
            S1: begin
                hwy   = YELLOW;
                cntry = RED;
            end
            S2: begin
                hwy   = RED;
                cntry = RED;
            end
            S3: begin
                hwy   = RED;
                cntry = GREEN;
            end
            S4: begin
                hwy   = RED;
                cntry = YELLOW;
            end
            default: begin
                hwy   = RED;
                cntry = RED;
            end
        endcase
    end

    assign state = state_r;

endmodule

// File: tb/tb_sig_control_timed.sv
// Self-checking bench for sig_control_timed: cycle scoreboard plus directed timing scenarios.
module tb_sig_control_timed;

    localparam int Y2R = 3;
    localparam int R2G = 2;
    localparam int HMG = 8;
    localparam int CMG = 16;
    localparam int DMAX = 31;

    logic       clock;
    logic       clear;
    logic       X;
    logic       preempt;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] state;

    int checks;
    int passes;

    int m_state;
    int m_dwell;
    logic [11:0] exp_q[$];

    sig_control_timed #(
        .Y2R_CYCLES(Y2R), .R2G_CYCLES(R2G), .HWY_MIN_GREEN(HMG),
        .CNTRY_MAX_GREEN(CMG), .CNT_W(5)
    ) dut (
        .clock(clock), .clear(clear), .X(X), .preempt(preempt),
        .hwy(hwy), .cntry(cntry), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int model_next(int s, int d, logic x, logic p);
        case (s)
            0: return (x && !p && d >= HMG - 1) ? 1 : 0;
            1: return (d == Y2R - 1) ? 2 : 1;
            2: return (d == R2G - 1) ? (p ? 0 : 3) : 2;
            3: return (!x || p || d == CMG - 1) ? 4 : 3;
            4: return (d == Y2R - 1) ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_lights(int s);
        case (s)
            0: return {2'd2, 2'd0};
            1: return {2'd1, 2'd0};
            2: return {2'd0, 2'd0};
            3: return {2'd0, 2'd2};
            4: return {2'd0, 2'd1};
            default: return {2'd0, 2'd0};
        endcase
    endfunction

    // Called at a falling edge: drives inputs, predicts the next edge, waits one cycle.
    task automatic step(input logic x, input logic p);
        int ns;
        X = x;
        preempt = p;
        ns = model_next(m_state, m_dwell, x, p);
        if (ns != m_state) m_dwell = 0;
        else if (m_dwell < DMAX) m_dwell = m_dwell + 1;
        m_state = ns;
        exp_q.push_back({3'(m_state), model_lights(m_state), 5'(m_dwell)});
        @(negedge clock);
    endtask

    task automatic do_clear();
        X = 1'b0;
        preempt = 1'b0;
        clear = 1'b1;
        exp_q.delete();
        @(negedge clock);
        clear = 1'b0;
        m_state = 0;
        m_dwell = 0;
    endtask

    // Scoreboard: compare each predicted post-edge snapshot and the head-conflict rule.
    always begin
        logic [11:0] e;
        logic [11:0] got;
        @(posedge clock);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            got = {state, hwy, cntry, dut.dwell_r};
            checks++;
            if (got !== e) $display("FAIL scoreboard t=%0t got st=%0d hwy=%0d cntry=%0d dwell=%0d want st=%0d hwy=%0d cntry=%0d dwell=%0d",
                                    $time, got[11:9], got[8:7], got[6:5], got[4:0], e[11:9], e[8:7], e[6:5], e[4:0]);
            else passes++;
            checks++;
            if (hwy !== 2'd0 && cntry !== 2'd0) $display("FAIL head_conflict t=%0t hwy=%0d cntry=%0d want one RED", $time, hwy, cntry);
            else passes++;
        end
    end

    task automatic test_reset();
        #1;
        checks++;
        if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passes++;
        checks++;
        if (hwy !== 2'd2) $display("FAIL reset_hwy got %0d want 2", hwy); else passes++;
        checks++;
        if (cntry !== 2'd0) $display("FAIL reset_cntry got %0d want 0", cntry); else passes++;
        @(negedge clock);
        do_clear();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        checks++;
        if (dut.dwell_r !== 5'd31) $display("FAIL idle_dwell_sat got %0d want 31", dut.dwell_r); else passes++;
        checks++;
        if (state !== 3'd0) $display("FAIL idle_state got %0d want 0", state); else passes++;
    endtask

    task automatic test_max_green();
        int rs[$];
        int rl[$];
        int cur;
        int len;
        int exp_s[6] = '{0, 1, 2, 3, 4, 0};
        int exp_l[6] = '{8, 3, 2, 16, 3, 8};
        do_clear();
        cur = int'(state);
        len = 0;
        for (int i = 0; i < 45; i++) begin
            if (int'(state) == cur) len++;
            else begin
                rs.push_back(cur); rl.push_back(len);
                cur = int'(state); len = 1;
            end
            step(1'b1, 1'b0);
        end
        checks++;
        if (rs.size() < 6) $display("FAIL maxg_runs got %0d runs want >=6", rs.size());
        else begin
            passes++;
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (rs[k] != exp_s[k] || rl[k] != exp_l[k])
                    $display("FAIL maxg_run%0d got S%0d x%0d want S%0d x%0d", k, rs[k], rl[k], exp_s[k], exp_l[k]);
                else passes++;
            end
        end
    endtask

    task automatic test_short_request();
        int rs[$];
        int rl[$];
        int cur;
        int len;
        int exp_s[5] = '{0, 1, 2, 3, 4};
        int exp_l[5] = '{1, 3, 2, 1, 3};
        do_clear();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        cur = int'(state);
        len = 0;
        for (int i = 0; i < 14; i++) begin
            if (int'(state) == cur) len++;
            else begin
                rs.push_back(cur); rl.push_back(len);
                cur = int'(state); len = 1;
            end
            step(i == 0, 1'b0);
        end
        checks++;
        if (rs.size() < 5) $display("FAIL short_runs got %0d runs want >=5", rs.size());
        else begin
            passes++;
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (rs[k] != exp_s[k] || rl[k] != exp_l[k])
                    $display("FAIL short_run%0d got S%0d x%0d want S%0d x%0d", k, rs[k], rl[k], exp_s[k], exp_l[k]);
                else passes++;
            end
        end
    endtask

    task automatic test_preempt();
        int bad;
        do_clear();
        for (int i = 0; i < 40 && state !== 3'd3; i++) step(1'b1, 1'b0);
        checks++;
        if (state !== 3'd3) $display("FAIL pre_reach_s3 got %0d want 3", state); else passes++;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (state !== 3'd4) $display("FAIL pre_s3_exit got %0d want 4", state); else passes++;
        for (int i = 0; i < 40 && state !== 3'd2; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (state !== 3'd2) $display("FAIL pre_s2_hold got %0d want 2", state); else passes++;
        step(1'b1, 1'b1);
        checks++;
        if (state !== 3'd0) $display("FAIL pre_s2_to_s0 got %0d want 0", state); else passes++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            if (state !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL pre_s0_hold got %0d non-S0 cycles want 0", bad); else passes++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_async_clear();
        int bad;
        do_clear();
        for (int i = 0; i < 40 && state !== 3'd3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2;
        clear = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (state !== 3'd0 || hwy !== 2'd2 || cntry !== 2'd0)
            $display("FAIL async_clear got st=%0d hwy=%0d cntry=%0d want 0/2/0", state, hwy, cntry);
        else passes++;
        @(negedge clock);
        clear = 1'b0;
        m_state = 0;
        m_dwell = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (state !== 3'd0) bad++;
            step(1'b1, 1'b0);
        end
        checks++;
        if (bad != 0) $display("FAIL async_min_green got %0d early exits want 0", bad); else passes++;
        checks++;
        if (state !== 3'd1) $display("FAIL async_s1_after_8 got %0d want 1", state); else passes++;
    endtask

    task automatic test_illegal_state();
        do_clear();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        force dut.state_r = 3'd6;
        #1;
        release dut.state_r;
        #1;
        checks++;
        if (state !== 3'd6 || hwy !== 2'd0 || cntry !== 2'd0)
            $display("FAIL illegal_decode got st=%0d hwy=%0d cntry=%0d want 6/0/0", state, hwy, cntry);
        else passes++;
        m_state = 6;
        step(1'b0, 1'b0);
        checks++;
        if (state !== 3'd0 || dut.dwell_r !== 5'd0)
            $display("FAIL illegal_recover got st=%0d dwell=%0d want 0/0", state, dut.dwell_r);
        else passes++;
        step(1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        m_state = 0;
        m_dwell = 0;
        clear = 1'b1;
        X = 1'b0;
        preempt = 1'b0;
        test_reset();
        test_idle();
        test_max_green();
        test_short_request();
        test_preempt();
        test_async_clear();
        test_illegal_state();
        @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached, %0d/%0d passed", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
